// File: rtl/qed_dup_scheduler_pkg.sv
// qed_dup_scheduler_pkg: shared FSM encoding and default sizes for the QED scheduler
package qed_dup_scheduler_pkg;
  typedef enum logic [1:0] {
    QED_RUN   = 2'd0,
    QED_DRAIN = 2'd1,
    QED_DONE  = 2'd2
  } qed_state_e;
  localparam int QED_DEPTH = 16;
  localparam int QED_CNT_W = 8;
endpackage

// File: rtl/qed_dup_scheduler_fifo.sv
// qed_dup_scheduler_fifo: in-order FIFO of duplicate-transformed instructions
module qed_dup_scheduler_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [31:0] i_data,
  output logic [31:0] o_head,
  output logic        o_full,
  output logic        o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [31:0] r_mem [DEPTH];
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_head  = o_empty ? 32'h0 : r_mem[r_rd[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
    end
  end
  // storage needs no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler: chooses original vs duplicate per fetch slot and tracks QED consistency
module qed_dup_scheduler
  import qed_dup_scheduler_pkg::*;
#(
  parameter int DEPTH = QED_DEPTH,
  parameter int CNT_W = QED_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             exec_dup_req,
  input  logic             drain_req,
  input  logic             fetch_valid,
  input  logic [31:0]      dup_instruction_in,
  output logic             exec_dup,
  output logic [31:0]      qed_instruction,
  output logic [CNT_W-1:0] orig_count,
  output logic [CNT_W-1:0] dup_count,
  output logic             qed_ready,
  output logic             fifo_full,
  output logic             cnt_sat
);
  qed_state_e       r_state;
  qed_state_e       w_state_nx;
  logic [CNT_W-1:0] r_orig;
  logic [CNT_W-1:0] r_dup;
  logic             r_sat;
  logic             r_ready;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_sat_nx;
  qed_dup_scheduler_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (dup_instruction_in),
    .o_head  (qed_instruction),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // select, slot actions and next state; a full FIFO forces a duplicate so a push never overflows
  always_comb begin
    exec_dup   = ena && !w_empty && (r_state == QED_DRAIN || exec_dup_req || w_full);
    w_push     = ena && fetch_valid && r_state == QED_RUN && !exec_dup;
    w_pop      = ena && fetch_valid && r_state != QED_DONE && exec_dup;
    w_sat_nx   = r_sat || (w_push && &r_orig) || (w_pop && &r_dup);
    w_state_nx = !ena ? r_state :
                 (r_state == QED_RUN && drain_req) ? QED_DRAIN :
                 (r_state == QED_DRAIN && w_empty) ? QED_DONE : r_state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= QED_RUN;
    else r_state <= w_state_nx;
  end
  // saturating counters, sticky saturation flag and ready register one cycle behind the counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_orig  <= '0;
      r_dup   <= '0;
      r_sat   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      if (w_push && !(&r_orig)) r_orig <= r_orig + 1'b1;
      if (w_pop && !(&r_dup)) r_dup <= r_dup + 1'b1;
      r_sat <= w_sat_nx;
      if (ena) r_ready <= (r_orig == r_dup) && (r_orig != '0) && !w_sat_nx;
    end
  end
  assign orig_count = r_orig;
  assign dup_count  = r_dup;
  assign cnt_sat    = r_sat;
  assign qed_ready  = r_ready;
  assign fifo_full  = w_full;
endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb_qed_dup_scheduler: directed checks of the QED duplicate scheduler
module tb_qed_dup_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        exec_dup_req = 1'b0;
  logic        drain_req = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] din = 32'h0;
  logic        exec_dup, qed_ready, fifo_full, cnt_sat;
  logic [31:0] qed_instruction;
  logic [7:0]  orig_count, dup_count;
  logic        s_exec_dup, s_ready, s_full, s_sat;
  logic [31:0] s_instr;
  logic [1:0]  s_orig, s_dup;
  int n_run = 0;
  int n_fail = 0;
  logic [31:0] exp_abc [3];

  always #5 clk = ~clk;

  qed_dup_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .exec_dup_req(exec_dup_req),
    .drain_req(drain_req), .fetch_valid(fetch_valid), .dup_instruction_in(din),
    .exec_dup(exec_dup), .qed_instruction(qed_instruction), .orig_count(orig_count),
    .dup_count(dup_count), .qed_ready(qed_ready), .fifo_full(fifo_full), .cnt_sat(cnt_sat)
  );

  qed_dup_scheduler #(.DEPTH(16), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .exec_dup_req(exec_dup_req),
    .drain_req(drain_req), .fetch_valid(fetch_valid), .dup_instruction_in(din),
    .exec_dup(s_exec_dup), .qed_instruction(s_instr), .orig_count(s_orig),
    .dup_count(s_dup), .qed_ready(s_ready), .fifo_full(s_full), .cnt_sat(s_sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ena = 1'b1; fetch_valid = 1'b0; exec_dup_req = 1'b0; drain_req = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_abc[0] = 32'hA0A0_0001;
    exp_abc[1] = 32'hB0B0_0002;
    exp_abc[2] = 32'hC0C0_0003;
    tick;
    do_reset;
    #1;
    chk("rst_exec_dup", exec_dup, 0);
    chk("rst_instr", qed_instruction, 0);
    chk("rst_orig", orig_count, 0);
    chk("rst_dup", dup_count, 0);
    chk("rst_ready", qed_ready, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_sat", cnt_sat, 0);
    // three originals then their three duplicates in order
    fetch_valid = 1'b1;
    din = exp_abc[0];
    #1 chk("empty_no_dup", exec_dup, 0);
    tick;
    chk("push_lat1", qed_instruction, exp_abc[0]);
    din = exp_abc[1]; tick;
    din = exp_abc[2]; tick;
    chk("abc_orig", orig_count, 3);
    exec_dup_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("abc_sel", exec_dup, 1);
      chk("abc_head", qed_instruction, exp_abc[i]);
      tick;
    end
    fetch_valid = 1'b0;
    chk("abc_dup", dup_count, 3);
    chk("abc_ready_lag", qed_ready, 0);
    tick;
    chk("abc_ready", qed_ready, 1);
    chk("abc_empty_head", qed_instruction, 0);
    // fill to DEPTH; full forces a duplicate
    fetch_valid = 1'b1; exec_dup_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = 32'h100 + i;
      tick;
    end
    #1;
    chk("full_flag", fifo_full, 1);
    chk("full_forced", exec_dup, 1);
    chk("full_head", qed_instruction, 32'h100);
    chk("full_orig", orig_count, 19);
    tick;
    chk("full_pop_head", qed_instruction, 32'h101);
    chk("full_pop_flag", fifo_full, 0);
    chk("full_pop_dup", dup_count, 4);
    chk("full_pop_orig", orig_count, 19);
    #1 chk("unforced", exec_dup, 0);
    // stall holds everything while the select still reflects the request
    fetch_valid = 1'b0; exec_dup_req = 1'b1;
    repeat (4) tick;
    chk("stall_sel", exec_dup, 1);
    chk("stall_dup", dup_count, 4);
    chk("stall_orig", orig_count, 19);
    chk("stall_head", qed_instruction, 32'h101);
    // pop down to two pending entries
    fetch_valid = 1'b1;
    repeat (13) tick;
    chk("pop13_dup", dup_count, 17);
    chk("pop13_head", qed_instruction, 32'h10E);
    // disable freezes state and blocks the select
    ena = 1'b0;
    #1 chk("ena0_sel", exec_dup, 0);
    repeat (3) tick;
    chk("ena0_dup", dup_count, 17);
    chk("ena0_orig", orig_count, 19);
    chk("ena0_head", qed_instruction, 32'h10E);
    ena = 1'b1;
    #1 chk("ena1_sel", exec_dup, 1);
    tick;
    chk("ena1_dup", dup_count, 18);
    chk("ena1_head", qed_instruction, 32'h10F);
    // drain five pending entries then stay in DONE
    do_reset;
    fetch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 32'h300 + i;
      tick;
    end
    chk("drn_orig", orig_count, 5);
    fetch_valid = 1'b0; drain_req = 1'b1;
    tick;
    drain_req = 1'b0; fetch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("drn_sel", exec_dup, 1);
      chk("drn_head", qed_instruction, 32'h300 + i);
      tick;
    end
    chk("drn_dup", dup_count, 5);
    chk("drn_empty_sel", exec_dup, 0);
    repeat (4) tick;
    exec_dup_req = 1'b1;
    #1;
    chk("done_orig", orig_count, 5);
    chk("done_dup", dup_count, 5);
    chk("done_ready", qed_ready, 1);
    chk("done_sel", exec_dup, 0);
    chk("done_head", qed_instruction, 0);
    // narrow counters saturate and suppress ready
    do_reset;
    fetch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 32'h400 + i;
      tick;
    end
    chk("sat_orig", s_orig, 3);
    chk("sat_flag", s_sat, 1);
    chk("sat_ready0", s_ready, 0);
    chk("wide_orig", orig_count, 4);
    chk("wide_sat", cnt_sat, 0);
    fetch_valid = 1'b0; drain_req = 1'b1;
    tick;
    drain_req = 1'b0; fetch_valid = 1'b1;
    repeat (4) tick;
    chk("sat_dup", s_dup, 3);
    repeat (3) tick;
    chk("sat_ready", s_ready, 0);
    chk("sat_sticky", s_sat, 1);
    chk("wide_dup", dup_count, 4);
    chk("wide_ready", qed_ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
